psum_accumulator: RTL and testbench

- Sits directly downstream of the 8-bit / dual-4-bit multiplier.
- Accumulates a programmed number of multiplier partial sums (psums) into one result and hands it downstream over a valid/ready handshake.
- Mode-aware:
  - mode 0: one full-width unsigned accumulator.
  - mode 1: two independent half-width lanes, upper half = a[7:4]*b products, lower half = a[3:0]*b products, with no carry between lanes.

---
 rtl/psum_accumulator.sv | 158 +++++++++++++++
 tb/tb_psum_accumulator.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_accumulator.sv
// ---------------------------------------------------------------------------
// psum_accumulator
//
// Purpose:
//   Sums a programmed number of partial sums (psums) from the 8-bit /
//   dual-4-bit multiplier into one result, then offers that result
//   downstream over a valid/ready handshake.
//   - mode 0: one full-width unsigned accumulator.
//   - mode 1: two independent half-width lanes with no carry between them.
//     The upper half holds a[7:4]*b products and the lower half holds
//     a[3:0]*b products.
//
// Parameters:
//   PSUM_W - psum and accumulator width. Must be even and >= 24. The default
//            of 32 matches the multiplier's product width.
//   LEN_W  - width of the accumulation-length field.
//
// Ports:
//   clk       in   sole clock, rising edge
//   rst       in   asynchronous, active-high reset
//   start     in   one-cycle job request; honoured only when idle
//   mode      in   0 = full width, 1 = dual half-width lanes (sampled at start)
//   acc_len   in   number of psums to accumulate (sampled at start)
//   in_valid  in   psum valid
//   in_ready  out  psum accepted this cycle when in_valid is also high
//   in_psum   in   multiplier product ({upper, lower} lanes in mode 1)
//   out_valid out  result valid
//   out_ready in   consumer accepts the result
//   out_sum   out  accumulated result
//   out_ovf   out  sticky carry flags:
//                    [0] = full width (mode 0) or lower lane (mode 1)
//                    [1] = upper lane (mode 1 only)
//   busy      out  high whenever a job is in progress or a result is pending
// ---------------------------------------------------------------------------
module psum_accumulator #(
    parameter int unsigned PSUM_W = 32,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [LEN_W-1:0]  acc_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PSUM_W-1:0] in_psum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PSUM_W-1:0] out_sum,
    output logic [1:0]        out_ovf,
    output logic              busy
);

    localparam int unsigned HALF_W = PSUM_W / 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              mode_q, mode_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [PSUM_W-1:0] acc_q, acc_d;
    logic [1:0]        ovf_q, ovf_d;

    // Adders carry one extra bit so the carry out can be captured as overflow.
    logic [PSUM_W:0]   sum_full;
    logic [HALF_W:0]   sum_lo;
    logic [HALF_W:0]   sum_hi;
    logic [PSUM_W-1:0] add_val;
    logic [1:0]        add_ovf;

    always_comb begin
        sum_full = {1'b0, acc_q} + {1'b0, in_psum};
        sum_lo   = {1'b0, acc_q[HALF_W-1:0]} + {1'b0, in_psum[HALF_W-1:0]};
        sum_hi   = {1'b0, acc_q[PSUM_W-1:HALF_W]} + {1'b0, in_psum[PSUM_W-1:HALF_W]};
        if (mode_q) begin
            // Lanes are summed separately, so a lower-lane carry never
            // reaches the upper lane.
            add_val = {sum_hi[HALF_W-1:0], sum_lo[HALF_W-1:0]};
            add_ovf = {sum_hi[HALF_W], sum_lo[HALF_W]};
        end else begin
            add_val = sum_full[PSUM_W-1:0];
            add_ovf = {1'b0, sum_full[PSUM_W]};
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    len_d   = acc_len;
                    cnt_d   = '0;
                    acc_d   = '0;
                    ovf_d   = '0;
                    state_d = (acc_len == '0) ? ST_OUT : ST_ACC;
                end
            end
            ST_ACC: begin
                if (in_valid) begin
                    acc_d = add_val;
                    ovf_d = ovf_q | add_ovf;
                    cnt_d = cnt_q + LEN_W'(1);
                    // Compare before incrementing so that the maximum length
                    // finishes without the counter wrapping.
                    if (cnt_q == len_q - LEN_W'(1)) begin
                        state_d = ST_OUT;
                    end
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= 1'b0;
            len_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    // Outputs come only from registers or a decode of the state, so there is
    // no combinational path from in_valid or out_ready.
    // The accumulator itself serves as out_sum: it holds the final value in
    // OUT and keeps it until the next start clears it.
    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_OUT);
    assign busy      = (state_q != ST_IDLE);
    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// ---------------------------------------------------------------------------
// tb_psum_accumulator
//
// Purpose:
//   Self-checking bench for psum_accumulator. It pairs a behavioural model
//   that tracks the job phase and sums accepted psums with plain arithmetic
//   against directed jobs that carry literal expected results, plus
//   randomized jobs.
// ---------------------------------------------------------------------------
module tb_psum_accumulator;

    localparam int PW = 32;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [LW-1:0] acc_len = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [PW-1:0] in_psum = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [PW-1:0] out_sum;
    logic [1:0]    out_ovf;
    logic          busy;

    int checks = 0;
    int failures = 0;

    psum_accumulator #(
        .PSUM_W (PW),
        .LEN_W  (LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .acc_len   (acc_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_psum   (in_psum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 collecting psums, 2 result pending
    int            m_phase = 0;
    logic          m_mode = 1'b0;
    int            m_len = 0;
    int            m_cnt = 0;
    logic [PW-1:0] m_sum = '0;
    logic [1:0]    m_ovf = '0;

    always @(posedge clk or posedge rst) begin
        logic [32:0] t;
        logic [16:0] lo;
        logic [16:0] hi;
        if (rst) begin
            m_phase = 0;
            m_sum = '0;
            m_ovf = '0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_mode = mode;
                    m_len = int'(acc_len);
                    m_cnt = 0;
                    m_sum = '0;
                    m_ovf = '0;
                    m_phase = (m_len == 0) ? 2 : 1;
                end
                1: if (in_valid) begin
                    if (m_mode) begin
                        lo = {1'b0, m_sum[15:0]} + {1'b0, in_psum[15:0]};
                        hi = {1'b0, m_sum[31:16]} + {1'b0, in_psum[31:16]};
                        if (lo[16]) m_ovf[0] = 1'b1;
                        if (hi[16]) m_ovf[1] = 1'b1;
                        m_sum = {hi[15:0], lo[15:0]};
                    end else begin
                        t = {1'b0, m_sum} + {1'b0, in_psum};
                        if (t[32]) m_ovf[0] = 1'b1;
                        m_sum = t[31:0];
                    end
                    m_cnt++;
                    if (m_cnt == m_len) m_phase = 2;
                end
                default: if (out_ready) m_phase = 0;
            endcase
        end
    end

    // Per-cycle comparison against the model. Sampled at the falling edge so
    // that DUT outputs have settled.
    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready", 64'(in_ready), 64'(m_phase == 1));
            check("out_valid", 64'(out_valid), 64'(m_phase == 2));
            check("busy", 64'(busy), 64'(m_phase != 0));
            // out_sum is only defined outside the collecting phase.
            if (m_phase != 1) begin
                check("out_sum", 64'(out_sum), 64'(m_sum));
                check("out_ovf", 64'(out_ovf), 64'(m_ovf));
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic start_job(input logic m, input int len);
        start = 1'b1;
        mode = m;
        acc_len = LW'(len);
        @(posedge clk);
        #1;
        start = 1'b0;
        // Scramble sampled fields; the DUT must ignore them after start.
        mode = 1'($urandom);
        acc_len = LW'($urandom);
    endtask

    // Offer one psum, preceded by up to maxb bubble cycles, until it is
    // accepted. start is sometimes pulsed during bubbles, and the DUT must
    // ignore it.
    task automatic feed(input logic [PW-1:0] p, input int maxb);
        int  nb;
        bit  acc;
        nb = (maxb > 0) ? int'($urandom_range(0, maxb)) : 0;
        in_valid = 1'b0;
        for (int i = 0; i < nb; i++) begin
            start = ($urandom_range(0, 3) == 0);
            in_psum = $urandom;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        in_valid = 1'b1;
        in_psum = p;
        acc = 1'b0;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) check("feed_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
        in_psum = $urandom;
    endtask

    // Wait for out_valid, optionally compare against literal values, hold
    // out_ready low for 'hold' cycles, then handshake with start also high.
    task automatic wait_result(input int hold, input bit lit, input logic [PW-1:0] es,
                               input logic [1:0] eo, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        if (!seen) begin
            check({name, "_timeout"}, 64'd0, 64'd1);
        end else if (lit) begin
            check({name, "_sum"}, 64'(out_sum), 64'(es));
            check({name, "_ovf"}, 64'(out_ovf), 64'(eo));
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < hold; i++) begin
            start = (i == 0);
            in_valid = 1'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        start = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic          rm;
        int            rl;
        logic [PW-1:0] rp;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_sum", 64'(out_sum), 64'd0);
        check("reset_ovf", 64'(out_ovf), 64'd0);
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;

        // 255*255 three times, full width.
        start_job(1'b0, 3);
        for (int i = 0; i < 3; i++) feed(32'd65025, 2);
        wait_result(5, 1'b1, 32'h0002_FA03, 2'b00, "m0_len3");

        // Dual-lane 0xFF*0xFF products four times.
        start_job(1'b1, 4);
        for (int i = 0; i < 4; i++) feed(32'h0EF1_0EF1, 2);
        wait_result(2, 1'b1, 32'h3BC4_3BC4, 2'b00, "m1_len4");

        // Lane isolation: a lower-lane carry must not reach the upper lane.
        start_job(1'b1, 2);
        feed(32'h0000_FFFF, 1);
        feed(32'h0000_0001, 1);
        wait_result(1, 1'b1, 32'h0000_0000, 2'b01, "m1_iso");

        start_job(1'b0, 2);
        feed(32'h0000_FFFF, 1);
        feed(32'h0000_0001, 1);
        wait_result(1, 1'b1, 32'h0001_0000, 2'b00, "m0_iso");

        // Upper-lane carry sets only flag [1].
        start_job(1'b1, 2);
        feed(32'hFFFF_0000, 0);
        feed(32'h0001_0000, 0);
        wait_result(0, 1'b1, 32'h0000_0000, 2'b10, "m1_hi_ovf");

        // Full-width wrap.
        start_job(1'b0, 2);
        feed(32'hFFFF_FFFF, 0);
        feed(32'h0000_0002, 0);
        wait_result(0, 1'b1, 32'h0000_0001, 2'b01, "m0_ovf");

        // Zero-length job.
        start_job(1'b0, 0);
        wait_result(3, 1'b1, 32'h0, 2'b00, "len0");

        // Maximum length.
        start_job(1'b0, 255);
        for (int i = 0; i < 255; i++) feed(32'd1, 0);
        wait_result(1, 1'b1, 32'd255, 2'b00, "len255");

        // Reset mid-job.
        start_job(1'b0, 4);
        feed(32'd100, 0);
        feed(32'd200, 0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_sum", 64'(out_sum), 64'd0);
        check("midrst_ready", 64'(in_ready), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_ovf", 64'(out_ovf), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        start_job(1'b0, 1);
        feed(32'd7, 0);
        wait_result(0, 1'b1, 32'd7, 2'b00, "after_rst");

        // Randomized jobs; the per-cycle compare checks these against the model.
        for (int j = 0; j < 40; j++) begin
            rm = 1'($urandom);
            rl = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 10));
            start_job(rm, rl);
            for (int k = 0; k < rl; k++) begin
                rp = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 65535));
                feed(rp, 3);
            end
            wait_result(int'($urandom_range(0, 5)), 1'b0, '0, '0, "rand");
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
